alu_cmd_sequencer: RTL and testbench

- Upstream feeder for the 4-bit combinational ALU (ADD/SUB/MUL/DIV selected by a 2-bit control).
- Accepts commands over a valid/ready interface, buffers them in a small FIFO, and drives the ALU's A/B/control inputs one command at a time.
- Captures the ALU's op/c_out and presents each result on a valid/ready response interface, in command order.
- Flags divide-by-zero itself, so downstream logic does not need to decode the ALU's 1111 error value.

---
 rtl/alu_cmd_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands in a FIFO and returns each ALU result in order on a valid/ready port.
// Latency: command accepted on edge E drives alu_* after E+1 and rsp_valid after E+3; one result per 3 cycles.
// Backpressure: cmd_ready = !full (registered count); rsp_* held until rsp_ready. Optional counters: ALU_SEQ_STATS_EN.

// alu_seq_fifo: generic synchronous FIFO, head word visible combinationally at o_dat.
// Latency: a word pushed on edge E is readable at o_dat after E.
// Backpressure: pushes while full and pops while empty are ignored.
module alu_seq_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_dat,
   input  logic         i_pop,
   output logic [W-1:0] o_dat,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_dat   = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         // Simultaneous push and pop leave the occupancy unchanged.
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_dat;
   end
endmodule

module alu_cmd_sequencer #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [1:0]        cmd_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_control,
   input  logic [DATA_W-1:0] alu_op,
   input  logic              alu_c_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_carry,
   output logic              rsp_err,
   output logic              busy,
   output logic [7:0]        stat_done,
   output logic [7:0]        stat_err
);
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [1:0]        op;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CAPTURE, S_HOLD} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   cmd_t              w_cmd_in;
   cmd_t              w_cmd_head;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_rsp_hs;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [1:0]        r_alu_ctrl;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_carry;
   logic              r_rsp_err;

   assign w_cmd_in  = {cmd_a, cmd_b, cmd_op};
   assign cmd_ready = !w_full;
   assign w_push    = cmd_valid && !w_full;
   assign w_rsp_hs  = r_rsp_valid && rsp_ready;

   alu_seq_fifo #(
      .W     ($bits(cmd_t)),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_dat   (w_cmd_in),
      .i_pop   (w_pop),
      .o_dat   (w_cmd_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_DRIVE;
            end
         end
         S_DRIVE:   w_state_nxt = S_CAPTURE;
         S_CAPTURE: w_state_nxt = S_HOLD;
         S_HOLD: begin
            // Chain straight into the next command to keep a 3-cycle cadence.
            if (w_rsp_hs) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_DRIVE;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_ctrl <= '0;
      end else if (w_pop) begin
         r_alu_a    <= w_cmd_head.a;
         r_alu_b    <= w_cmd_head.b;
         r_alu_ctrl <= w_cmd_head.op;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_carry <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else if (r_state == S_CAPTURE) begin
         r_rsp_valid <= 1'b1;
         r_rsp_data  <= alu_op;
         r_rsp_carry <= alu_c_out;
         r_rsp_err   <= (r_alu_ctrl == 2'b11) && (r_alu_b == '0);
      end else if (w_rsp_hs) begin
         r_rsp_valid <= 1'b0;
      end
   end

`ifdef ALU_SEQ_STATS_EN
   logic [7:0] r_stat_done;
   logic [7:0] r_stat_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_done <= '0;
         r_stat_err  <= '0;
      end else if (w_rsp_hs) begin
         if (r_stat_done != 8'hFF)             r_stat_done <= r_stat_done + 8'd1;
         if (r_rsp_err && r_stat_err != 8'hFF) r_stat_err  <= r_stat_err + 8'd1;
      end
   end

   assign stat_done = r_stat_done;
   assign stat_err  = r_stat_err;
`else
   assign stat_done = '0;
   assign stat_err  = '0;
`endif

   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_control = r_alu_ctrl;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;
   assign rsp_carry   = r_rsp_carry;
   assign rsp_err     = r_rsp_err;
   assign busy        = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural 4-bit ALU attached to its alu_* port.
// Expected responses are queued when a command is accepted and compared when the response handshakes.
module tb_alu_cmd_sequencer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic [1:0] cmd_op;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [1:0] alu_control;
   logic [3:0] alu_op;
   logic       alu_c_out;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_data;
   logic       rsp_carry;
   logic       rsp_err;
   logic       busy;
   logic [7:0] stat_done;
   logic [7:0] stat_err;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.DATA_W(4), .DEPTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_op      (cmd_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_control (alu_control),
      .alu_op      (alu_op),
      .alu_c_out   (alu_c_out),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_carry   (rsp_carry),
      .rsp_err     (rsp_err),
      .busy        (busy),
      .stat_done   (stat_done),
      .stat_err    (stat_err)
   );

   // Behavioural ALU: ADD/SUB carry/borrow, MUL overflow flag, DIV by zero gives 1111.
   logic [7:0] alu_prod;
   assign alu_prod = {4'd0, alu_a} * {4'd0, alu_b};
   always_comb begin
      alu_op    = 4'd0;
      alu_c_out = 1'b0;
      case (alu_control)
         2'b00: {alu_c_out, alu_op} = {1'b0, alu_a} + {1'b0, alu_b};
         2'b01: {alu_c_out, alu_op} = {1'b0, alu_a} - {1'b0, alu_b};
         2'b10: begin
            alu_op    = alu_prod[3:0];
            alu_c_out = |alu_prod[7:4];
         end
         default: alu_op = (alu_b == 4'd0) ? 4'hF : alu_a / alu_b;
      endcase
   end

   typedef struct packed {
      logic [3:0] d;
      logic       c;
      logic       e;
   } rsp_t;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] op;
      logic [3:0] d;
      logic       c;
      logic       e;
   } vec_t;

   rsp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   int         n_acc  = 0;
   int         n_rsp  = 0;
   logic       prev_vld = 1'b0;
   logic       prev_hs  = 1'b0;
   rsp_t       prev_r;
   vec_t       vt[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic rsp_t ref_rsp(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      int unsigned ia;
      int unsigned ib;
      int unsigned r;
      rsp_t        o;
      ia = a;
      ib = b;
      o  = '0;
      case (op)
         2'b00: begin r = ia + ib; o.d = r[3:0]; o.c = r[4]; end
         2'b01: begin r = (ia - ib) & 32'h1F; o.d = r[3:0]; o.c = r[4]; end
         2'b10: begin r = ia * ib; o.d = r[3:0]; o.c = (r > 15); end
         default: begin
            if (ib == 0) begin o.d = 4'hF; o.e = 1'b1; end
            else begin r = ia / ib; o.d = r[3:0]; end
         end
      endcase
      return o;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input rsp_t exp);
      int   t;
      logic acc;
      t   = 0;
      acc = 1'b0;
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      while (!acc && t < 300) begin
         @(negedge clk);
         if (cmd_ready) acc = 1'b1;
         else t++;
      end
      if (acc) begin
         sb_q.push_back(exp);
         n_acc++;
      end else begin
         checks++;
         errors++;
         $display("FAIL push_timeout: cmd_ready stayed 0, expected 1 within 300 cycles");
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((sb_q.size() != 0 || busy) && t < 600) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 600) begin
         errors++;
         $display("FAIL %s: %0d responses outstanding, expected 0", name, sb_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      sb_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Response monitor: ordering via scoreboard, stability while held, no unexpected responses.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_vld = 1'b0;
         prev_hs  = 1'b0;
      end else begin
         if (prev_vld && !prev_hs) begin
            chk("rsp_valid_held", rsp_valid, 1);
            chk("rsp_held_stable", {rsp_data, rsp_carry, rsp_err}, prev_r);
         end
         if (rsp_valid && sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stale_rsp: rsp_valid=1 data=%0h, expected no response", rsp_data);
         end else if (rsp_valid && rsp_ready) begin
            rsp_t e;
            e = sb_q.pop_front();
            chk("rsp_data", rsp_data, e.d);
            chk("rsp_carry", rsp_carry, e.c);
            chk("rsp_err", rsp_err, e.e);
            n_rsp++;
         end
         prev_vld = rsp_valid;
         prev_hs  = rsp_valid && rsp_ready;
         prev_r   = {rsp_data, rsp_carry, rsp_err};
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 400000");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{a: 4'h3, b: 4'h5, op: 2'b00, d: 4'h8, c: 1'b0, e: 1'b0};
      vt[1]  = '{a: 4'hF, b: 4'h1, op: 2'b00, d: 4'h0, c: 1'b1, e: 1'b0};
      vt[2]  = '{a: 4'h3, b: 4'h5, op: 2'b01, d: 4'hE, c: 1'b1, e: 1'b0};
      vt[3]  = '{a: 4'h1, b: 4'h0, op: 2'b11, d: 4'hF, c: 1'b0, e: 1'b1};
      vt[4]  = '{a: 4'h4, b: 4'h2, op: 2'b11, d: 4'h2, c: 1'b0, e: 1'b0};
      vt[5]  = '{a: 4'h3, b: 4'h5, op: 2'b10, d: 4'hF, c: 1'b0, e: 1'b0};
      vt[6]  = '{a: 4'h5, b: 4'h5, op: 2'b10, d: 4'h9, c: 1'b1, e: 1'b0};
      vt[7]  = '{a: 4'h7, b: 4'h2, op: 2'b11, d: 4'h3, c: 1'b0, e: 1'b0};
      vt[8]  = '{a: 4'h9, b: 4'h4, op: 2'b01, d: 4'h5, c: 1'b0, e: 1'b0};
      vt[9]  = '{a: 4'h0, b: 4'h0, op: 2'b00, d: 4'h0, c: 1'b0, e: 1'b0};
      vt[10] = '{a: 4'hF, b: 4'h0, op: 2'b11, d: 4'hF, c: 1'b0, e: 1'b1};
      vt[11] = '{a: 4'h0, b: 4'h3, op: 2'b11, d: 4'h0, c: 1'b0, e: 1'b0};

      cmd_a  = 4'd0;
      cmd_b  = 4'd0;
      cmd_op = 2'd0;
      do_reset();

      // Reset state.
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_alu", {alu_a, alu_b, alu_control}, 0);
      chk("rst_rsp", {rsp_data, rsp_carry, rsp_err}, 0);
      chk("rst_stats", {stat_done, stat_err}, 0);
      @(posedge clk);
      #1;

      // Latency: accept on edge E, alu_* after E+1, rsp_valid after E+3.
      rsp_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_a     = 4'h3;
      cmd_b     = 4'h5;
      cmd_op    = 2'b00;
      @(negedge clk);
      chk("lat_cmd_ready", cmd_ready, 1);
      sb_q.push_back('{d: 4'h8, c: 1'b0, e: 1'b0});
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("lat_e0_alu_a", alu_a, 4'h0);
      chk("lat_e0_busy", busy, 1);
      @(negedge clk);
      chk("lat_e1_alu", {alu_a, alu_b, alu_control}, {4'h3, 4'h5, 2'b00});
      chk("lat_e1_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      chk("lat_e2_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      chk("lat_e3_rsp_valid", rsp_valid, 1);
      @(negedge clk);
      chk("lat_e4_rsp_valid", rsp_valid, 0);
      chk("lat_e4_busy", busy, 0);
      chk("idle_alu_kept", {alu_a, alu_b}, {4'h3, 4'h5});
      @(posedge clk);
      #1;

      // Table-driven vectors, back to back.
      for (int i = 0; i < 12; i++)
         push(vt[i].a, vt[i].b, vt[i].op, '{d: vt[i].d, c: vt[i].c, e: vt[i].e});
      drain("table_drain");

      // Backpressure: rsp_ready low, six commands offered back to back.
      rsp_ready = 1'b0;
      n_acc     = 0;
      fork
         begin
            push(4'h2, 4'h3, 2'b00, ref_rsp(4'h2, 4'h3, 2'b00));
            push(4'h8, 4'h1, 2'b01, ref_rsp(4'h8, 4'h1, 2'b01));
            push(4'h6, 4'h0, 2'b11, ref_rsp(4'h6, 4'h0, 2'b11));
            push(4'h4, 4'h4, 2'b10, ref_rsp(4'h4, 4'h4, 2'b10));
            push(4'hC, 4'h5, 2'b11, ref_rsp(4'hC, 4'h5, 2'b11));
            push(4'hA, 4'h7, 2'b00, ref_rsp(4'hA, 4'h7, 2'b00));
         end
         begin
            int t;
            t = 0;
            while (n_acc < 5 && t < 100) begin
               @(negedge clk);
               t++;
            end
            chk("bp_accepted", n_acc, 5);
            repeat (5) begin
               @(negedge clk);
               chk("bp_cmd_ready_low", cmd_ready, 0);
               chk("bp_no_extra_accept", n_acc, 5);
               chk("bp_rsp_valid", rsp_valid, 1);
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
         end
      join
      drain("bp_drain");
      chk("bp_total_accepted", n_acc, 6);

      // Reset during DRIVE of the second of three commands.
      begin
         int base;
         int t;
         base = n_rsp;
         push(4'h1, 4'h2, 2'b00, ref_rsp(4'h1, 4'h2, 2'b00));
         push(4'h5, 4'h3, 2'b10, ref_rsp(4'h5, 4'h3, 2'b10));
         push(4'h9, 4'h3, 2'b11, ref_rsp(4'h9, 4'h3, 2'b11));
         t = 0;
         while (n_rsp == base && t < 50) begin
            @(negedge clk);
            t++;
         end
         chk("mid_first_rsp", n_rsp, base + 1);
         @(posedge clk);
         #1;
         rst_n = 1'b0;
         sb_q.delete();
         repeat (2) @(posedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         chk("mid_rsp_valid", rsp_valid, 0);
         chk("mid_busy", busy, 0);
         chk("mid_cmd_ready", cmd_ready, 1);
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mid_no_stale", rsp_valid, 0);
         end
         @(posedge clk);
         #1;
      end

      // Statistics: 300 responses, two of them divide-by-zero.
      do_reset();
      rsp_ready = 1'b1;
      n_rsp     = 0;
      for (int i = 0; i < 300; i++) begin
         logic [3:0] a;
         logic [3:0] b;
         logic [1:0] op;
         a  = 4'($urandom_range(0, 15));
         b  = 4'($urandom_range(0, 15));
         op = 2'(i % 4);
         if (op == 2'b11) b = (i == 51 || i == 203) ? 4'd0 : 4'($urandom_range(1, 15));
         push(a, b, op, ref_rsp(a, b, op));
      end
      drain("stats_drain");
      chk("stats_rsp_count", n_rsp, 300);
`ifdef ALU_SEQ_STATS_EN
      chk("stat_done_sat", stat_done, 255);
      chk("stat_err", stat_err, 2);
`else
      chk("stat_done_tied", stat_done, 0);
      chk("stat_err_tied", stat_err, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
